// File: rtl/rast_iter_pkg.sv
// Shared types, sizes and subsample helpers for the sample iterator.
package rast_iter_pkg;

  localparam int SIGFIG = 24;
  localparam int RADIX  = 10;
  localparam int VERTS  = 3;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;

  typedef logic [SIGFIG-1:0]                        coord_t;
  typedef logic [1:0][SIGFIG-1:0]                   pt_t;
  typedef logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]   tri_t;
  typedef logic [COLORS-1:0][SIGFIG-1:0]            color_t;

  typedef enum logic {WAIT_STATE, TEST_STATE} iter_state_t;

  // One-hot subsample mode to log2 of samples per pixel edge.
  // The lowest set bit wins if more than one bit is set.
  function automatic int ss_lg2(input logic [3:0] sub_sample);
    if (sub_sample[0])      return 3;
    else if (sub_sample[1]) return 2;
    else if (sub_sample[2]) return 1;
    else                    return 0;
  endfunction

  // Sample pitch in fixed point for a given subsample log2.
  function automatic coord_t ss_step(input int lg2);
    coord_t one;
    one = coord_t'(1);
    return one << (RADIX - lg2);
  endfunction

endpackage

// File: rtl/smpl_iter_if.sv
// Bundle of the bbox-side handshake and the sample-stream outputs.
// SMPL_ITER_CNT_EN adds the per-triangle sample count and done pulse.
interface smpl_iter_if;
  import rast_iter_pkg::*;

  tri_t           tri_R13S;
  color_t         color_R13U;
  logic [1:0][1:0][SIGFIG-1:0] box_R13S;
  logic           validTri_R13H;
  logic           halt_RnnnnH;
  logic [3:0]     subSample_RnnnnU;
  logic           halt_R13H;
  tri_t           tri_R14S;
  color_t         color_R14U;
  pt_t            sample_R14S;
  logic           validSamp_R14H;
`ifdef SMPL_ITER_CNT_EN
  logic [31:0]    sampCount_R14U;
  logic           triDone_R14H;
`endif

  modport master (
    output tri_R13S, color_R13U, box_R13S, validTri_R13H, halt_RnnnnH, subSample_RnnnnU,
    input  halt_R13H, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
`ifdef SMPL_ITER_CNT_EN
    , input sampCount_R14U, triDone_R14H
`endif
  );

  modport slave (
    input  tri_R13S, color_R13U, box_R13S, validTri_R13H, halt_RnnnnH, subSample_RnnnnU,
    output halt_R13H, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
`ifdef SMPL_ITER_CNT_EN
    , output sampCount_R14U, triDone_R14H
`endif
  );

endinterface

// File: rtl/dff.sv
// Enabled register cleared by an asynchronous active-low reset.
module dff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Load d when enabled, clear immediately on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/smpl_iter.sv
// Sample iterator: takes one bounded triangle and walks its box in raster
// order at subsample pitch, one candidate sample per cycle.
// Optional feature macro: SMPL_ITER_CNT_EN (sample count + last-sample pulse).
module smpl_iter
  import rast_iter_pkg::*;
(
  input logic        clk,
  input logic        rst,
  smpl_iter_if.slave bus
);

  localparam int EXT = SIGFIG + 1;

  iter_state_t state, state_nxt;
  logic        en;
  logic        box_empty;
  logic        x_adv, y_adv;

  tri_t   tri_q, tri_d;
  color_t color_q, color_d;
  pt_t    sample_q, sample_d;
  pt_t    ur_q, ur_d;
  coord_t ll_x_q, ll_x_d;
  coord_t step_q, step_d;

  logic signed [EXT-1:0] x_nxt, y_nxt, ur_x_ext, ur_y_ext;

  // A downstream stall freezes every register, including the FSM.
  assign en = ~bus.halt_RnnnnH;

  assign box_empty = ($signed(bus.box_R13S[1][0]) < $signed(bus.box_R13S[0][0])) |
                     ($signed(bus.box_R13S[1][1]) < $signed(bus.box_R13S[0][1]));

  // One extra bit keeps the step past the last column from wrapping negative.
  assign x_nxt    = $signed({sample_q[0][SIGFIG-1], sample_q[0]}) + $signed({1'b0, step_q});
  assign y_nxt    = $signed({sample_q[1][SIGFIG-1], sample_q[1]}) + $signed({1'b0, step_q});
  assign ur_x_ext = $signed({ur_q[0][SIGFIG-1], ur_q[0]});
  assign ur_y_ext = $signed({ur_q[1][SIGFIG-1], ur_q[1]});
  assign x_adv    = (x_nxt <= ur_x_ext);
  assign y_adv    = (y_nxt <= ur_y_ext);

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    state <= WAIT_STATE;
    else if (en) state <= state_nxt;
  end

  // Next state and next sample position; the triangle is captured on accept.
  always_comb begin
    state_nxt = state;
    tri_d     = tri_q;
    color_d   = color_q;
    sample_d  = sample_q;
    ur_d      = ur_q;
    ll_x_d    = ll_x_q;
    step_d    = step_q;
    case (state)
      WAIT_STATE: begin
        if (bus.validTri_R13H) begin
          tri_d    = bus.tri_R13S;
          color_d  = bus.color_R13U;
          sample_d = bus.box_R13S[0];
          ur_d     = bus.box_R13S[1];
          ll_x_d   = bus.box_R13S[0][0];
          step_d   = ss_step(ss_lg2(bus.subSample_RnnnnU));
          if (!box_empty) state_nxt = TEST_STATE;
        end
      end
      TEST_STATE: begin
        if (x_adv) begin
          sample_d[0] = x_nxt[SIGFIG-1:0];
        end else if (y_adv) begin
          sample_d[0] = ll_x_q;
          sample_d[1] = y_nxt[SIGFIG-1:0];
        end else begin
          state_nxt = WAIT_STATE;
        end
      end
      default: state_nxt = WAIT_STATE;
    endcase
  end

  dff #(.WIDTH($bits(tri_t)))   u_tri    (.clk(clk), .rst(rst), .en(en), .d(tri_d),    .q(tri_q));
  dff #(.WIDTH($bits(color_t))) u_color  (.clk(clk), .rst(rst), .en(en), .d(color_d),  .q(color_q));
  dff #(.WIDTH($bits(pt_t)))    u_sample (.clk(clk), .rst(rst), .en(en), .d(sample_d), .q(sample_q));
  dff #(.WIDTH($bits(pt_t)))    u_ur     (.clk(clk), .rst(rst), .en(en), .d(ur_d),     .q(ur_q));
  dff #(.WIDTH(SIGFIG))         u_ll_x   (.clk(clk), .rst(rst), .en(en), .d(ll_x_d),   .q(ll_x_q));
  dff #(.WIDTH(SIGFIG))         u_step   (.clk(clk), .rst(rst), .en(en), .d(step_d),   .q(step_q));

  assign bus.halt_R13H      = (state == TEST_STATE);
  assign bus.validSamp_R14H = (state == TEST_STATE);
  assign bus.tri_R14S       = tri_q;
  assign bus.color_R14U     = color_q;
  assign bus.sample_R14S    = sample_q;

`ifdef SMPL_ITER_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  // Count starts at 1 with the first sample and clears when the box retires.
  always_comb begin
    cnt_d = cnt_q;
    case (state)
      WAIT_STATE: if (bus.validTri_R13H && !box_empty) cnt_d = 32'd1;
      TEST_STATE: cnt_d = (x_adv || y_adv) ? cnt_q + 32'd1 : 32'd0;
      default:    cnt_d = 32'd0;
    endcase
  end

  dff #(.WIDTH(32)) u_cnt (.clk(clk), .rst(rst), .en(en), .d(cnt_d), .q(cnt_q));

  assign bus.sampCount_R14U = cnt_q;
  assign bus.triDone_R14H   = (state == TEST_STATE) & ~x_adv & ~y_adv;
`endif

endmodule

// File: tb/tb_smpl_iter.sv
// Scoreboard bench for smpl_iter: raster-walk reference model feeds an
// expected-sample queue, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_smpl_iter;
  import rast_iter_pkg::*;

  typedef struct {
    coord_t x;
    coord_t y;
    tri_t   tri_v;
    color_t col;
    int     seq;
    bit     last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  smpl_iter_if bus();
  smpl_iter dut (.clk(clk), .rst(rst), .bus(bus));

  exp_t exp_q[$];
  exp_t mon_e;
  int   compared   = 0;
  int   mismatched = 0;
  int   pop_count  = 0;
  bit   rand_halt  = 1'b0;

  task automatic checkOutput(input string name, input logic [255:0] got, input logic [255:0] req);
    compared++;
    if (got !== req) begin
      mismatched++;
      $display("[TB] FAIL %s got=%0h required=%0h at %0t", name, got, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_halt) bus.halt_RnnnnH = ($urandom_range(0, 3) == 0);
  endtask

  function automatic longint step_of(input logic [3:0] ss);
    case (ss)
      4'b0001: return 128;
      4'b0010: return 256;
      4'b0100: return 512;
      default: return 1024;
    endcase
  endfunction

  // Drive one triangle, push its expected samples, then follow it to completion.
  // stall_at / reset_at: number of samples consumed before the event (-1 = none).
  // exp_cycles: required busy cycles (-1 = not checked).
  task automatic applyStimulus(input longint llx, input longint lly, input longint urx,
                               input longint ury, input logic [3:0] ss, input int stall_at,
                               input int reset_at, input int exp_cycles);
    tri_t   t;
    color_t c;
    longint step;
    int     n, budget, base, cycles, stall_left;
    bit     stalled;
    for (int i = 0; i < VERTS*AXIS; i++) t[i/AXIS][i%AXIS] = coord_t'($urandom);
    for (int i = 0; i < COLORS; i++) c[i] = coord_t'($urandom);
    step = step_of(ss);
    bus.tri_R13S         = t;
    bus.color_R13U       = c;
    bus.box_R13S[0][0]   = coord_t'(llx);
    bus.box_R13S[0][1]   = coord_t'(lly);
    bus.box_R13S[1][0]   = coord_t'(urx);
    bus.box_R13S[1][1]   = coord_t'(ury);
    bus.subSample_RnnnnU = ss;
    bus.validTri_R13H    = 1'b1;
    budget = 0;
    while (!(bus.halt_R13H === 1'b0 && bus.halt_RnnnnH === 1'b0)) begin
      tick();
      budget++;
      if (budget > 200) begin
        checkOutput("accept_timeout", 256'(budget), 256'(0));
        bus.validTri_R13H = 1'b0;
        return;
      end
    end
    n = 0;
    for (longint y = lly; y <= ury; y += step)
      for (longint x = llx; x <= urx; x += step) begin
        n++;
        exp_q.push_back('{coord_t'(x), coord_t'(y), t, c, n, 1'b0});
      end
    if (n > 0) exp_q[exp_q.size()-1].last = 1'b1;
    base = pop_count;
    tick();
    bus.validTri_R13H    = 1'b0;
    bus.subSample_RnnnnU = 4'b0001;
    bus.box_R13S         = '0;
    if (n == 0) begin
      checkOutput("empty_valid", 256'(bus.validSamp_R14H), 256'(0));
      checkOutput("empty_halt", 256'(bus.halt_R13H), 256'(0));
      return;
    end
    checkOutput("latency1_valid", 256'(bus.validSamp_R14H), 256'(1));
    cycles = 0;
    stall_left = 0;
    stalled = 1'b0;
    while (bus.halt_R13H === 1'b1 && cycles < 3000) begin
      if (reset_at >= 0 && pop_count - base == reset_at) begin
        rst = 1'b0;
        #1;
        checkOutput("rst_valid", 256'(bus.validSamp_R14H), 256'(0));
        checkOutput("rst_halt", 256'(bus.halt_R13H), 256'(0));
        checkOutput("rst_sample", 256'(bus.sample_R14S), 256'(0));
        checkOutput("rst_tri", 256'(bus.tri_R14S), 256'(0));
        checkOutput("rst_color", 256'(bus.color_R14U), 256'(0));
`ifdef SMPL_ITER_CNT_EN
        checkOutput("rst_count", 256'(bus.sampCount_R14U), 256'(0));
`endif
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        tick();
        return;
      end
      if (stall_at >= 0 && pop_count - base == stall_at && !stalled) begin
        stalled = 1'b1;
        stall_left = 3;
      end
      if (stall_left > 0) begin
        bus.halt_RnnnnH = 1'b1;
        stall_left--;
      end else if (!rand_halt) begin
        bus.halt_RnnnnH = 1'b0;
      end
      cycles++;
      tick();
    end
    if (cycles >= 3000) checkOutput("drain_timeout", 256'(cycles), 256'(0));
    if (exp_cycles >= 0) checkOutput("busy_cycles", 256'(cycles), 256'(exp_cycles));
    checkOutput("queue_drained", 256'(exp_q.size()), 256'(0));
    checkOutput("idle_valid", 256'(bus.validSamp_R14H), 256'(0));
  endtask

  // Monitor: compare the presented sample with the queue head, pop when consumed.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && bus.validSamp_R14H === 1'b1) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_sample", 256'(bus.sample_R14S), 256'(0));
          if (bus.sample_R14S == '0) begin
            mismatched++;
            $display("[TB] FAIL unexpected_sample got=valid required=idle at %0t", $time);
          end
        end else begin
          mon_e = exp_q[0];
          checkOutput("sample_xy", 256'(bus.sample_R14S), 256'({mon_e.y, mon_e.x}));
          checkOutput("sample_tri", 256'(bus.tri_R14S), 256'(mon_e.tri_v));
          checkOutput("sample_color", 256'(bus.color_R14U), 256'(mon_e.col));
          checkOutput("halt_R13H_busy", 256'(bus.halt_R13H), 256'(1));
`ifdef SMPL_ITER_CNT_EN
          checkOutput("sampCount", 256'(bus.sampCount_R14U), 256'(mon_e.seq));
          checkOutput("triDone", 256'(bus.triDone_R14H), 256'(mon_e.last));
`endif
          if (bus.halt_RnnnnH === 1'b0) begin
            void'(exp_q.pop_front());
            pop_count++;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=running required=finished at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    longint step, llx, lly, nx, ny;
    bus.tri_R13S         = '0;
    bus.color_R13U       = '0;
    bus.box_R13S         = '0;
    bus.validTri_R13H    = 1'b0;
    bus.halt_RnnnnH      = 1'b0;
    bus.subSample_RnnnnU = 4'b1000;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_valid", 256'(bus.validSamp_R14H), 256'(0));
    checkOutput("reset_halt", 256'(bus.halt_R13H), 256'(0));
    checkOutput("reset_sample", 256'(bus.sample_R14S), 256'(0));
    @(negedge clk);
    rst = 1'b1;
    tick();

    applyStimulus(0, 0, 1024, 1024, 4'b1000, -1, -1, 4);
    applyStimulus(0, 0, 1024, 1024, 4'b0100, -1, -1, 9);
    applyStimulus(0, 0, 1024, 1024, 4'b0100, 1, -1, 12);
    applyStimulus(2048, 3072, 2048, 3072, 4'b1000, -1, -1, 1);
    applyStimulus(2048, 0, 1024, 0, 4'b1000, -1, -1, -1);
    applyStimulus(0, 0, 1024, 1024, 4'b0100, -1, 4, -1);
    applyStimulus(512, 512, 1024, 1024, 4'b0100, -1, -1, 4);
    applyStimulus(8387584, 0, 8387584, 1024, 4'b1000, -1, -1, 2);
    applyStimulus(-8388608, -1024, -8387584, -1024, 4'b1000, -1, -1, 2);
    applyStimulus(-256, -256, 0, 0, 4'b0001, -1, -1, 9);

    rand_halt = 1'b1;
    repeat (25) begin
      k    = int'($urandom_range(0, 3));
      step = 128 << k;
      llx  = (longint'($urandom_range(0, 40)) - 20) * step;
      lly  = (longint'($urandom_range(0, 40)) - 20) * step;
      nx   = longint'($urandom_range(0, 4)) - 1;
      ny   = longint'($urandom_range(0, 4)) - 1;
      applyStimulus(llx, lly, llx + nx*step, lly + ny*step, 4'(1 << k), -1, -1, -1);
    end
    rand_halt = 1'b0;
    bus.halt_RnnnnH = 1'b0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
